// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, scheduler states and counter width for the MDU sequencer.
`default_nettype none

package mdu_pkg;

   localparam int CNT_W = 4;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN_MUL = 2'd1,
      RUN_DIV = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_lat_counter.sv
// mdu_lat_counter: loadable down-counter tracking the remaining MDU busy cycles.
`default_nettype none

module mdu_lat_counter
   import mdu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - ONE;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == ONE);

endmodule

`default_nettype wire

// File: rtl/mdu_sched.sv
// mdu_sched: issues MDU start pulses, tracks fixed latency, drives HI/LO writes,
// the Decode-stage MDU stall and a sticky protocol-violation flag.
`default_nettype none

module mdu_sched
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_E,
   input  logic [3:0]       op_E,
   input  logic             md_D,
   output logic             start,
   output logic [1:0]       hilo_we,
   output logic             busy,
   output logic             stall_md,
   output logic [CNT_W-1:0] cnt,
   output logic             err
);

   if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
      $error("mdu_sched: MULT_CYCLES must be in 1..15");
   end
   if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
      $error("mdu_sched: DIV_CYCLES must be in 1..15");
   end

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   state_e           state_q, state_d;
   logic             err_q, err_d;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             last;
   logic             idle;
   logic             is_md_op;
   logic             is_mul_op;
   logic             is_mt_op;
   logic             issue;
   logic             viol;

   mdu_lat_counter u_lat_counter (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .load_val_i (load_val),
      .en_i       (busy),
      .cnt_o      (cnt),
      .last_o     (last)
   );

   // Requests are gated by reset so all Mealy outputs drop the instant reset asserts.
   assign idle      = (state_q == IDLE);
   assign busy      = !idle;
   assign is_mul_op = (op_E == OP_MULT) || (op_E == OP_MULTU);
   assign is_md_op  = is_mul_op || (op_E == OP_DIV) || (op_E == OP_DIVU);
   assign is_mt_op  = (op_E == OP_MTHI) || (op_E == OP_MTLO);
   assign issue     = reset && valid_E && is_md_op && idle;
   assign viol      = reset && valid_E && (is_md_op || is_mt_op) && busy;
   assign start     = issue;
   assign stall_md  = md_D && (busy || start);

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = '0;
      hilo_we  = 2'b00;
      err_d    = err_q | viol;
      case (state_q)
         IDLE: begin
            if (issue) begin
               load = 1'b1;
               if (is_mul_op) begin
                  state_d  = RUN_MUL;
                  load_val = MULT_LD;
               end else begin
                  state_d  = RUN_DIV;
                  load_val = DIV_LD;
               end
            end else if (reset && valid_E && (op_E == OP_MTHI)) begin
               hilo_we = 2'b10;
            end else if (reset && valid_E && (op_E == OP_MTLO)) begin
               hilo_we = 2'b01;
            end
         end
         RUN_MUL, RUN_DIV: begin
            if (last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed self-checking bench for the MDU sequencing controller.
`default_nettype none

module tb_mdu_sched;

   logic       clk;
   logic       reset;
   logic       valid_E;
   logic [3:0] op_E;
   logic       md_D;
   logic       start;
   logic [1:0] hilo_we;
   logic       busy;
   logic       stall_md;
   logic [3:0] cnt;
   logic       err;

   int n_checks;
   int n_errors;

   mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .valid_E  (valid_E),
      .op_E     (op_E),
      .md_D     (md_D),
      .start    (start),
      .hilo_we  (hilo_we),
      .busy     (busy),
      .stall_md (stall_md),
      .cnt      (cnt),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge, then drive new inputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic md);
      valid_E = v;
      op_E    = op;
      md_D    = md;
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b0;
      valid_E  = 1'b0;
      op_E     = 4'd0;
      md_D     = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_start", start, 0);
      step();
      reset = 1'b1;
      step();

      // mult issue and 5-cycle countdown
      drive(1, 4'd1, 0);
      chk("mul_start", start, 1);
      chk("mul_busy0", busy, 0);
      chk("mul_hilo", hilo_we, 0);
      step();
      drive(0, 4'd0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("mul_busy", busy, 1);
         chk("mul_cnt", cnt, 5 - i);
         chk("mul_nostart", start, 0);
         step();
      end
      chk("mul_done_busy", busy, 0);
      chk("mul_done_cnt", cnt, 0);

      // div with mflo waiting in Decode
      drive(1, 4'd3, 1);
      chk("div_start", start, 1);
      chk("div_stall_issue", stall_md, 1);
      step();
      drive(0, 4'd0, 1);
      for (int i = 0; i < 10; i++) begin
         chk("div_busy", busy, 1);
         chk("div_cnt", cnt, 10 - i);
         chk("div_stall", stall_md, 1);
         step();
      end
      chk("div_idle_busy", busy, 0);
      chk("div_idle_stall", stall_md, 0);

      // mthi / mtlo / unused op codes in IDLE
      drive(1, 4'd5, 0);
      chk("mthi_we", hilo_we, 2);
      chk("mthi_start", start, 0);
      chk("mthi_stall", stall_md, 0);
      step();
      chk("mthi_busy", busy, 0);
      drive(1, 4'd6, 0);
      chk("mtlo_we", hilo_we, 1);
      step();
      chk("mtlo_cnt", cnt, 0);
      drive(1, 4'd9, 0);
      chk("op9_start", start, 0);
      chk("op9_we", hilo_we, 0);
      step();
      drive(0, 4'd0, 0);
      chk("op9_busy", busy, 0);
      chk("op9_err", err, 0);
      chk("idle_we", hilo_we, 0);

      // violation on the third busy cycle of a mult run
      drive(1, 4'd1, 0);
      chk("v_start", start, 1);
      step();
      drive(0, 4'd0, 0);
      step();
      step();
      drive(1, 4'd2, 0);
      chk("v_cnt3", cnt, 3);
      chk("v_nostart", start, 0);
      step();
      drive(0, 4'd0, 0);
      chk("v_cnt2", cnt, 2);
      chk("v_err", err, 1);
      chk("v_busy", busy, 1);
      step();
      drive(1, 4'd5, 0);
      chk("v_last_cnt", cnt, 1);
      chk("v_last_nostart", start, 0);
      chk("v_last_we", hilo_we, 0);
      step();
      drive(0, 4'd0, 0);
      chk("v_after_busy", busy, 0);
      chk("v_after_cnt", cnt, 0);
      chk("v_err_sticky", err, 1);

      // reset asserted mid-div at cnt=6
      drive(1, 4'd4, 0);
      chk("r_start", start, 1);
      step();
      drive(0, 4'd0, 0);
      repeat (4) step();
      chk("r_cnt6", cnt, 6);
      #2;
      reset   = 1'b0;
      valid_E = 1'b1;
      op_E    = 4'($urandom_range(1, 6));
      md_D    = 1'($urandom_range(0, 1));
      #1;
      chk("r_busy", busy, 0);
      chk("r_cnt", cnt, 0);
      chk("r_err", err, 0);
      chk("r_nostart", start, 0);
      chk("r_nowe", hilo_we, 0);
      chk("r_nostall", stall_md, 0);
      step();
      drive(0, 4'd0, 0);
      reset = 1'b1;
      step();
      drive(1, 4'd1, 0);
      chk("r2_start", start, 1);
      step();
      drive(0, 4'd0, 0);
      chk("r2_cnt5", cnt, 5);
      repeat (4) step();
      chk("r2_cnt1", cnt, 1);
      chk("r2_busy", busy, 1);
      step();
      chk("r2_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
